// File: rtl/uart_report_framer.sv
// ---------------------------------------------------------------------------
// uart_report_framer
//   Telemetry framer placed in front of uart_tx and beside uart_rx. Emits
//   framed ASCII-hex reports of NUM_FIELDS measurement fields either on a
//   periodic timer or on request, with an optional XOR checksum byte.
//   Fields are snapshotted coherently when a frame starts. Every byte that
//   arrives from uart_rx is queued in an echo FIFO and sent back between
//   frames.
//
//   Frame: HEADER, LEN, NUM_FIELDS*FIELD_W/4 ASCII hex nibbles (field 0
//   first, MSB nibble first), [XOR checksum of all preceding bytes], 8'h0A.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   field_data      packed fields, field k = [k*FIELD_W +: FIELD_W]
//   send_req        one-cycle pulse requesting a frame
//   rx_data/_valid  received bytes (always accepted)
//   tx_data/_valid  byte stream towards uart_tx, held until tx_data_ready
//   tx_data_ready   uart_tx accepts the byte when valid && ready
//   busy            high from field snapshot until terminator accepted
//   frame_done      high in the cycle the terminator is accepted
//   echo_overflow   one-cycle pulse when an rx byte is dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_report_framer #(
    parameter int          CLK_FRE     = 50,
    parameter int          PERIOD_MS   = 1000,
    parameter int          NUM_FIELDS  = 4,
    parameter int          FIELD_W     = 16,
    parameter logic [7:0]  HEADER      = 8'hAD,
    parameter int          CHECKSUM_EN = 1,
    parameter int          ECHO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_FIELDS*FIELD_W-1:0] field_data,
    input  logic                          send_req,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_data_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_data_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          echo_overflow
);

    localparam int NIB    = FIELD_W / 4;
    localparam int NHEX   = NUM_FIELDS * NIB;
    localparam int LEN    = 2 + NHEX + CHECKSUM_EN + 1;
    localparam int SNAP_W = NUM_FIELDS * FIELD_W;
    localparam int AW     = $clog2(ECHO_DEPTH);

    localparam logic [7:0] LEN_B    = 8'(LEN);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
    localparam logic [7:0] HEX_END  = 8'(2 + NHEX);

    localparam longint unsigned PERIOD_CYC = longint'(CLK_FRE) * 64'd1000 * longint'(PERIOD_MS);
    localparam int TMR_W = (PERIOD_CYC > 64'd1) ? $clog2(PERIOD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_ECHO = 2'd3
    } state_t;

    // ASCII upper-case hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, n};
        end else begin
            hex_ascii = 8'h37 + {4'h0, n};
        end
    endfunction

    // Running XOR checksum step.
    function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
        xor_acc = acc ^ b;
    endfunction

    state_t              r_state;
    state_t              w_state_n;
    logic                r_pending;
    logic                w_wrap;

    logic [7:0]          r_tx_data,  w_tx_data_n;
    logic                r_tx_valid, w_tx_valid_n;
    logic                r_busy,     w_busy_n;
    logic [7:0]          r_idx,      w_idx_n;
    logic [SNAP_W-1:0]   r_snap,     w_snap_n;
    logic [7:0]          r_chk,      w_chk_n;
    logic                r_echo_ovf;

    logic [SNAP_W-1:0]   w_pack;
    logic [SNAP_W-1:0]   w_snap_shift;
    logic                w_accept;
    logic                w_last;
    logic                w_cur_hex;
    logic [7:0]          w_nidx;
    logic [7:0]          w_chk_nxt;
    logic [7:0]          w_next_byte;

    logic [7:0]          r_mem [ECHO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    // ---------------- periodic timer ----------------
    if (PERIOD_MS > 0) begin : g_timer
        logic [TMR_W-1:0] r_timer;

        // Free-running period counter; wrap raises a report request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_timer <= '0;
            end else if (r_timer == TMR_W'(PERIOD_CYC - 64'd1)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end

        assign w_wrap = (r_timer == TMR_W'(PERIOD_CYC - 64'd1));
    end else begin : g_no_timer
        assign w_wrap = 1'b0;
    end

    // Request latch: new requests win over the clear in LOAD so that a
    // request arriving while the frame is being set up is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (send_req || w_wrap) begin
            r_pending <= 1'b1;
        end else if (r_state == S_LOAD) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= r_pending;
        end
    end

    // ---------------- echo FIFO ----------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // The head is only popped once uart_tx has taken it, so it stays put
    // on tx_data for the whole handshake.
    assign w_pop   = (r_state == S_ECHO) && w_accept;
    assign w_push  = rx_data_valid && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // FIFO storage (no reset needed: contents are qualified by the pointers).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    // FIFO pointers and drop indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_echo_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            r_echo_ovf <= rx_data_valid && w_full && !w_pop;
        end
    end

    // ---------------- frame datapath helpers ----------------
    // Reorder fields so that field 0 sits at the top of the snapshot; the
    // next nibble to send is then always the top nibble after a left shift.
    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_pack
        assign w_pack[(NUM_FIELDS-1-k)*FIELD_W +: FIELD_W] = field_data[k*FIELD_W +: FIELD_W];
    end

    assign w_accept     = r_tx_valid && tx_data_ready;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_cur_hex    = (r_idx >= 8'd2) && (r_idx < HEX_END);
    assign w_snap_shift = w_cur_hex ? (r_snap << 4) : r_snap;
    assign w_nidx       = r_idx + 8'd1;
    assign w_chk_nxt    = xor_acc(r_chk, r_tx_data);

    // Byte that follows the one currently being accepted.
    always_comb begin
        w_next_byte = 8'h0A;
        if (w_nidx == 8'd1) begin
            w_next_byte = LEN_B;
        end else if (w_nidx < HEX_END) begin
            w_next_byte = hex_ascii(w_snap_shift[SNAP_W-1 -: 4]);
        end else if ((CHECKSUM_EN != 0) && (w_nidx == HEX_END)) begin
            w_next_byte = w_chk_nxt;
        end else begin
            w_next_byte = 8'h0A;
        end
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic; IDLE re-arbitrates per echo byte, frames first.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_n = S_LOAD;
                end else if (!w_empty) begin
                    w_state_n = S_ECHO;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_n = S_SEND;
            end
            S_SEND: begin
                if (w_accept && w_last) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_SEND;
                end
            end
            S_ECHO: begin
                if (w_accept) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_ECHO;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Output / datapath next values; tx_data only changes on acceptance
    // or when a new byte is first presented.
    always_comb begin
        w_tx_data_n  = r_tx_data;
        w_tx_valid_n = r_tx_valid;
        w_busy_n     = r_busy;
        w_idx_n      = r_idx;
        w_snap_n     = r_snap;
        w_chk_n      = r_chk;
        case (r_state)
            S_IDLE: begin
                if (w_state_n == S_ECHO) begin
                    w_tx_data_n  = w_head;
                    w_tx_valid_n = 1'b1;
                end else begin
                    w_tx_valid_n = 1'b0;
                end
            end
            S_LOAD: begin
                w_snap_n     = w_pack;
                w_idx_n      = 8'd0;
                w_chk_n      = 8'd0;
                w_tx_data_n  = HEADER;
                w_tx_valid_n = 1'b1;
                w_busy_n     = 1'b1;
            end
            S_SEND: begin
                if (w_accept && w_last) begin
                    w_tx_valid_n = 1'b0;
                    w_busy_n     = 1'b0;
                end else if (w_accept) begin
                    w_idx_n      = w_nidx;
                    w_chk_n      = w_chk_nxt;
                    w_snap_n     = w_snap_shift;
                    w_tx_data_n  = w_next_byte;
                end else begin
                    w_tx_valid_n = 1'b1;
                end
            end
            S_ECHO: begin
                if (w_accept) begin
                    w_tx_valid_n = 1'b0;
                end else begin
                    w_tx_valid_n = 1'b1;
                end
            end
            default: begin
                w_tx_valid_n = 1'b0;
                w_busy_n     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_idx      <= 8'd0;
            r_snap     <= '0;
            r_chk      <= 8'd0;
        end else begin
            r_tx_data  <= w_tx_data_n;
            r_tx_valid <= w_tx_valid_n;
            r_busy     <= w_busy_n;
            r_idx      <= w_idx_n;
            r_snap     <= w_snap_n;
            r_chk      <= w_chk_n;
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign busy          = r_busy;
    assign echo_overflow = r_echo_ovf;
    // Must coincide with the accepting cycle, so it is decoded from the
    // registered state and the live ready input.
    assign frame_done    = (r_state == S_SEND) && w_accept && w_last;

endmodule

// File: tb/tb_uart_report_framer.sv
module tb_uart_report_framer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: request-only framer
    logic [63:0] a_field;
    logic        a_req, a_rxv, a_ready;
    logic [7:0]  a_rx;
    logic [7:0]  a_txd;
    logic        a_txv, a_busy, a_done, a_ovf;

    // instance B: 1000-cycle periodic framer
    logic [63:0] b_field;
    logic        b_req, b_rxv, b_ready;
    logic [7:0]  b_rx;
    logic [7:0]  b_txd;
    logic        b_txv, b_busy, b_done, b_ovf;

    uart_report_framer #(.PERIOD_MS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .field_data(a_field), .send_req(a_req),
        .rx_data(a_rx), .rx_data_valid(a_rxv), .tx_data(a_txd),
        .tx_data_valid(a_txv), .tx_data_ready(a_ready), .busy(a_busy),
        .frame_done(a_done), .echo_overflow(a_ovf)
    );

    uart_report_framer #(.CLK_FRE(1), .PERIOD_MS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .field_data(b_field), .send_req(b_req),
        .rx_data(b_rx), .rx_data_valid(b_rxv), .tx_data(b_txd),
        .tx_data_valid(b_txv), .tx_data_ready(b_ready), .busy(b_busy),
        .frame_done(b_done), .echo_overflow(b_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_frame [20];

    // monitor state
    int         cyc       = 0;
    logic [7:0] q[$];
    int         done_q[$];
    int         rise_q[$];
    int         b_rise_q[$];
    int         fd_cnt    = 0;
    int         ovf_cnt   = 0;
    int         stab_err  = 0;
    int         b_acc     = 0;
    logic       a_busy_d  = 1'b0;
    logic       b_busy_d  = 1'b0;
    logic       a_hold_d  = 1'b0;
    logic [7:0] a_txd_d   = 8'd0;

    // Capture accepted bytes and event times; flag any change of a held byte.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (a_txv && a_ready) q.push_back(a_txd);
            if (a_done) begin
                fd_cnt <= fd_cnt + 1;
                done_q.push_back(cyc);
            end
            if (a_ovf) ovf_cnt <= ovf_cnt + 1;
            if (a_busy && !a_busy_d) rise_q.push_back(cyc);
            if (a_hold_d && (!a_txv || (a_txd != a_txd_d))) stab_err <= stab_err + 1;
            if (b_txv && b_ready) b_acc <= b_acc + 1;
            if (b_busy && !b_busy_d) b_rise_q.push_back(cyc);
        end
        a_busy_d <= a_busy;
        b_busy_d <= b_busy;
        a_hold_d <= a_txv && !a_ready;
        a_txd_d  <= a_txd;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int base, input int n,
                              input int budget, input bit rnd);
        int k = 0;
        while ((q.size() < base + n) && (k < budget)) begin
            @(negedge clk);
            a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        a_ready = 1'b1;
        check_val(tag, q.size() - base, n);
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int i = 0; i < 20; i++) begin
            if (base + i < q.size()) check_val(tag, q[base + i], exp_frame[i]);
            else                     check_val(tag, 32'hFFFF_FFFF, exp_frame[i]);
        end
    endtask

    initial begin
        int base, fd0, ov0, k, bcnt;
        exp_frame = '{8'hAD, 8'h14, 8'h31, 8'h41, 8'h32, 8'h42, 8'h30, 8'h30, 8'h30, 8'h33,
                      8'h46, 8'h46, 8'h46, 8'h46, 8'h30, 8'h30, 8'h30, 8'h30, 8'hBA, 8'h0A};
        a_field = {16'h0000, 16'hFFFF, 16'h0003, 16'h1A2B};
        a_req = 1'b0; a_rx = 8'd0; a_rxv = 1'b0; a_ready = 1'b1;
        b_field = 64'h0123_4567_89AB_CDEF;
        b_req = 1'b0; b_rx = 8'd0; b_rxv = 1'b0; b_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_valid", a_txv, 1'b0);
        check_val("rst_busy",  a_busy, 1'b0);
        check_val("rst_done",  a_done, 1'b0);
        check_val("rst_ovf",   a_ovf, 1'b0);
        check_val("rst_data",  a_txd, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic frame and request latency
        base = q.size(); fd0 = fd_cnt;
        pulse_req();
        check_val("lat_c1", a_txv, 1'b0);
        @(negedge clk);
        check_val("lat_c2", a_txv, 1'b0);
        @(negedge clk);
        check_val("lat_c3_valid", a_txv, 1'b1);
        check_val("lat_c3_data",  a_txd, 8'hAD);
        check_val("lat_c3_busy",  a_busy, 1'b1);
        wait_bytes("t1_count", base, 20, 200, 1'b0);
        check_frame("t1_byte", base);
        repeat (5) @(negedge clk);
        check_val("t1_done_cnt", fd_cnt - fd0, 1);
        check_val("t1_busy_end", a_busy, 1'b0);

        // 2: random back-pressure, fields change after snapshot
        base = q.size();
        pulse_req();
        repeat (2) @(negedge clk);
        a_field = 64'hDEAD_BEEF_5A5A_C3C3;
        wait_bytes("t2_count", base, 20, 600, 1'b1);
        check_frame("t2_byte", base);
        check_val("t2_stable", stab_err, 0);
        a_field = {16'h0000, 16'hFFFF, 16'h0003, 16'h1A2B};
        repeat (5) @(negedge clk);

        // 3: three requests during busy merge into one extra frame
        base = q.size(); fd0 = fd_cnt;
        pulse_req();
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            a_req = 1'b1;
            @(negedge clk);
            a_req = 1'b0;
        end
        wait_bytes("t3_count", base, 40, 400, 1'b0);
        repeat (60) @(negedge clk);
        check_val("t3_total", q.size() - base, 40);
        check_val("t3_done_cnt", fd_cnt - fd0, 2);
        check_frame("t3_f2_byte", base + 20);
        if ((done_q.size() > fd0) && (rise_q.size() > 0))
            check_val("t3_order", (rise_q[rise_q.size() - 1] > done_q[fd0]) ? 1 : 0, 1);
        else
            check_val("t3_order", 0, 1);

        // 4: echo of bytes received mid-frame
        base = q.size();
        pulse_req();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            a_rx = 8'h41 + 8'(i); a_rxv = 1'b1;
            @(negedge clk);
        end
        a_rxv = 1'b0;
        wait_bytes("t4_count", base, 25, 400, 1'b0);
        check_frame("t4_byte", base);
        for (int i = 0; i < 5; i++) check_val("t4_echo", q[base + 20 + i], 8'h41 + 8'(i));
        repeat (5) @(negedge clk);

        // 5: FIFO overflow
        base = q.size(); ov0 = ovf_cnt;
        pulse_req();
        for (int i = 0; i < 17; i++) begin
            a_rx = 8'h50 + 8'(i); a_rxv = 1'b1;
            @(negedge clk);
        end
        a_rxv = 1'b0;
        wait_bytes("t5_count", base, 36, 400, 1'b0);
        repeat (40) @(negedge clk);
        check_val("t5_total", q.size() - base, 36);
        check_val("t5_ovf_cnt", ovf_cnt - ov0, 1);
        for (int i = 0; i < 16; i++) check_val("t5_echo", q[base + 20 + i], 8'h50 + 8'(i));

        // 6: periodic frames every 1000 cycles
        k = 0;
        while ((b_rise_q.size() < 3) && (k < 4000)) begin
            @(negedge clk);
            k++;
        end
        check_val("t6_rises", (b_rise_q.size() >= 3) ? 1 : 0, 1);
        if (b_rise_q.size() >= 3) begin
            check_val("t6_period1", b_rise_q[1] - b_rise_q[0], 1000);
            check_val("t6_period2", b_rise_q[2] - b_rise_q[1], 1000);
        end

        // reset in the middle of a periodic frame
        k = 0;
        while (!b_busy && (k < 1500)) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        check_val("t6_midframe", b_txv, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", b_txv, 1'b0);
        check_val("t6_rst_data",  b_txd, 8'h00);
        check_val("t6_rst_busy",  b_busy, 1'b0);
        check_val("t6_rst_done",  b_done, 1'b0);
        check_val("t6_rst_ovf",   b_ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bcnt = b_acc;
        repeat (500) @(negedge clk);
        check_val("t6_no_resume", b_acc - bcnt, 0);
        check_val("t6_idle_busy", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
